demux_1x4_sched: RTL and testbench
==================================

Name: demux_1x4_sched

Overview:
Credit-based round-robin dispatcher that drives a 1x4 demux. It accepts a valid/ready input stream and picks one of four output channels per item. The item is held in a single output register until the selected channel accepts it. Sits in front of the 1x4 demux datapath, supplying its select and data, and shares the input source among four consumers.

Parameters:
WIDTH, 8, data width of in_data/out_data
CREDITS, 4, max outstanding items per channel (credit counter reset/max value, 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input item present
in_data  input  WIDTH  input item
in_ready  output  1  dispatcher can take item this cycle
out_data  output  WIDTH  registered data, broadcast to all channels
out_valid  output  4  one-hot; bit i = item held for channel i
out_ready  input  4  channel i accepts held item
sel  output  2  index of channel currently/last granted (demux select)
credit_ret  input  4  pulse: channel i returns one credit
mode  input  1  0 = round-robin, 1 = fixed channel
fix_sel  input  2  channel used when mode=1
err  output  1  sticky: credit return on a channel already at CREDITS

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, sel=0, err=0.
  - All credit counters = CREDITS.
  - RR pointer = 3, so the first round-robin grant goes to ch0.
- States:
  - EMPTY: out_valid==0.
  - HOLD: out_valid one-hot.
- Eligibility: channel i is eligible when its credit counter > 0 (registered value, before this cycle's updates). In mode=1 only fix_sel is considered; in mode=0 all four are.
- Grant:
  - mode=0: first eligible channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - mode=1: fix_sel if eligible, else no grant.
- in_ready (combinational) = (state==EMPTY or held item fires this cycle) and a grant exists. in_ready must not depend on in_valid.
- Fire = out_valid[sel] & out_ready[sel]. out_ready on non-selected channels is ignored.
- Accept (in_valid & in_ready), registered at the next edge:
  - out_data <= in_data; out_valid <= onehot(grant); sel <= grant.
  - Grant channel credit -1; ptr <= grant (round-robin mode only; mode=1 leaves ptr unchanged).
- Fire without accept: out_valid <= 0 → EMPTY. out_data and sel hold.
- Fire and accept in the same cycle: back-to-back, one item per clock, no bubble.
- HOLD without fire: out_data, out_valid and sel are stable; the input is not accepted.
- Credits:
  - credit_ret[i] adds 1; accept on i subtracts 1.
  - Both on the same channel in one cycle: net unchanged.
  - Return at CREDITS with no same-cycle consume: counter saturates, err <= 1 (cleared only by reset).
  - Several channels may return in one cycle.
- All credits 0, or the fixed channel at 0: in_ready=0, stall indefinitely, no error.
- mode/fix_sel changes take effect at the next grant evaluation. A held item is never re-routed.
- Latency: input to out_valid is one cycle. Throughput is 1/cycle when consumers are ready and have credits.
- Reset mid-HOLD: item dropped, out_valid=0 immediately (async).

Test Plan:
- Reset, mode=0, all out_ready=1, credit_ret echoes each fire one cycle later, in_data 0x10..0x17 every cycle → sel 0,1,2,3,0,1,2,3; out_valid 0001,0010,0100,1000 repeating; one item per clock.
- mode=0, no credit_ret, CREDITS=4, 20 items offered → exactly 16 accepted, then in_ready=0 with out_valid=0. Then credit_ret=0100 → next item goes to ch2 only.
- mode=1, fix_sel=2, out_ready[2]=0 for 5 cycles → out_valid=0100 and out_data held stable; in_ready=0. Raising out_ready[2] fires in that cycle and accepts the next item.
- Channel 1 credits forced to 0 (4 unreturned sends), mode=0 → the rotation skips ch1: 0,2,3,0,2.
- credit_ret[3] pulsed with ch3 at full credit → err=1 and stays 1; a same-cycle consume+return on ch0 leaves the ch0 count unchanged.
- rst_n low during HOLD → out_valid=0 without waiting for clk; after release, the first grant is ch0 and all credits are restored.

Source files
------------

// File: rtl/demux_1x4_sched.sv
// demux_1x4_sched: credit-based round-robin dispatcher feeding a 1x4 demux.
// One output register holds each item until its chosen channel accepts it.
module demux_1x4_sched #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       sel,
    input  logic [3:0]       credit_ret,
    input  logic             mode,
    input  logic [1:0]       fix_sel,
    output logic             err
);
    typedef enum logic {EMPTY, HOLD} state_t;
    localparam logic [3:0] CMAX = 4'(CREDITS);
    state_t state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0] sel_q, sel_d, ptr_q, ptr_d, gnt;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic [3:0] elig, hit, inc, dec;
    logic err_q, err_d, has_gnt, fire, accept;

    for (genvar g = 0; g < 4; g++) begin : g_elig
        assign elig[g] = cnt_q[g] != 4'd0;
    end

    // Round-robin search runs from ptr+4 down to ptr+1 so the nearest eligible channel wins.
    always_comb begin
        gnt = mode ? fix_sel : ptr_q;
        has_gnt = mode ? elig[fix_sel] : 1'b0;
        if (!mode) begin
            for (int k = 4; k >= 1; k--) begin
                if (elig[ptr_q + 2'(k)]) begin
                    gnt = ptr_q + 2'(k);
                    has_gnt = 1'b1;
                end
            end
        end
    end

    assign fire      = (state_q == HOLD) & out_ready[sel_q];
    assign in_ready  = ((state_q == EMPTY) | fire) & has_gnt;
    assign accept    = in_valid & in_ready;
    assign hit       = accept ? 4'b0001 << gnt : 4'b0000;
    assign inc       = credit_ret & ~hit;
    assign dec       = hit & ~credit_ret;
    assign out_valid = (state_q == HOLD) ? 4'b0001 << sel_q : 4'b0000;
    assign out_data  = data_q;
    assign sel       = sel_q;
    assign err       = err_q;

    always_comb begin
        state_d = accept ? HOLD : fire ? EMPTY : state_q;
        data_d  = accept ? in_data : data_q;
        sel_d   = accept ? gnt : sel_q;
        ptr_d   = (accept && !mode) ? gnt : ptr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = dec[i] ? cnt_q[i] - 4'd1 :
                       (inc[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 4'd1 : cnt_q[i];
            err_d = err_d | (inc[i] & (cnt_q[i] == CMAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            err_q   <= 1'b0;
            cnt_q   <= {4{CMAX}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_demux_1x4_sched.sv
// tb_demux_1x4_sched: directed bench for the credit-based 1x4 dispatcher.
module tb_demux_1x4_sched;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, mode = 1'b0;
    logic in_ready, err;
    logic [7:0] in_data = 8'h00, out_data;
    logic [3:0] out_valid, out_ready = 4'h0, credit_ret = 4'h0;
    logic [1:0] sel, fix_sel = 2'd0;
    logic [1:0] skip_seq [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    demux_1x4_sched #(.WIDTH(8), .CREDITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel(sel), .credit_ret(credit_ret),
        .mode(mode), .fix_sel(fix_sel), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        tick;
        rst_n = 1'b1;
        // Round-robin with credits echoed one cycle after each fire.
        mode = 1'b0;
        out_ready = 4'hF;
        for (int k = 0; k < 10; k++) begin
            in_valid = k < 8;
            in_data = 8'h10 + 8'(k);
            credit_ret = (k >= 2) ? 4'b0001 << ((k - 2) % 4) : 4'b0000;
            #1;
            if (k < 8) chk("rr_ready", 32'(in_ready), 32'h1);
            tick;
            if (k < 8) begin
                chk("rr_sel", 32'(sel), 32'(k % 4));
                chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (k % 4)));
                chk("rr_data", 32'(out_data), 32'(8'h10 + 8'(k)));
            end else begin
                chk("rr_drain", 32'(out_valid), 32'h0);
            end
        end
        credit_ret = 4'h0;
        chk("rr_err", 32'(err), 32'h0);
        // Credit exhaustion: 16 of 20 accepted.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data = 8'h20 + 8'(k);
            #1;
            chk("cr_ready", 32'(in_ready), 32'(k < 16));
            tick;
            chk("cr_valid", 32'(out_valid), (k < 16) ? 32'(4'b0001 << (k % 4)) : 32'h0);
        end
        in_valid = 1'b0;
        credit_ret = 4'b0100;
        #1;
        chk("cr_stall", 32'(in_ready), 32'h0);
        tick;
        credit_ret = 4'h0;
        in_valid = 1'b1;
        in_data = 8'h55;
        #1;
        chk("cr_ret_ready", 32'(in_ready), 32'h1);
        tick;
        chk("cr_ret_valid", 32'(out_valid), 32'h4);
        chk("cr_ret_sel", 32'(sel), 32'h2);
        chk("cr_ret_data", 32'(out_data), 32'h55);
        #1;
        chk("cr_ret_stall", 32'(in_ready), 32'h0);
        tick;
        chk("cr_ret_empty", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        credit_ret = 4'hF;
        repeat (4) tick;
        credit_ret = 4'h0;
        chk("cr_err", 32'(err), 32'h0);
        // Fixed channel 2 with backpressure.
        mode = 1'b1;
        fix_sel = 2'd2;
        out_ready = 4'b1011;
        in_valid = 1'b1;
        in_data = 8'hA0;
        #1;
        chk("fx_ready", 32'(in_ready), 32'h1);
        tick;
        chk("fx_valid", 32'(out_valid), 32'h4);
        chk("fx_data", 32'(out_data), 32'hA0);
        in_data = 8'hA1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fx_hold_ready", 32'(in_ready), 32'h0);
            tick;
            chk("fx_hold_valid", 32'(out_valid), 32'h4);
            chk("fx_hold_data", 32'(out_data), 32'hA0);
        end
        out_ready = 4'hF;
        #1;
        chk("fx_fire_ready", 32'(in_ready), 32'h1);
        tick;
        chk("fx_next_valid", 32'(out_valid), 32'h4);
        chk("fx_next_data", 32'(out_data), 32'hA1);
        in_valid = 1'b0;
        tick;
        chk("fx_empty", 32'(out_valid), 32'h0);
        credit_ret = 4'b0100;
        repeat (2) tick;
        credit_ret = 4'h0;
        // Fresh reset, drain ch1, then rotation must skip it.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mode = 1'b1;
        fix_sel = 2'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'h40 + 8'(k);
            #1;
            chk("sk_fill_ready", 32'(in_ready), 32'h1);
            tick;
            chk("sk_fill_valid", 32'(out_valid), 32'h2);
        end
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'h48 + 8'(k);
            #1;
            chk("sk_ready", 32'(in_ready), 32'h1);
            tick;
            chk("sk_sel", 32'(sel), 32'(skip_seq[k]));
        end
        in_valid = 1'b0;
        tick;
        // ch0 refilled to full, then consume+return on ch0 must not change its count.
        credit_ret = 4'b0001;
        repeat (2) tick;
        mode = 1'b1;
        fix_sel = 2'd0;
        in_valid = 1'b1;
        in_data = 8'h50;
        #1;
        chk("net_ready", 32'(in_ready), 32'h1);
        tick;
        chk("net_err", 32'(err), 32'h0);
        credit_ret = 4'h0;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'h51 + 8'(k);
            #1;
            chk("net_cnt_ready", 32'(in_ready), 32'(k < 4));
            tick;
        end
        in_valid = 1'b0;
        tick;
        // ch3 back to full, then an extra return sets the sticky error.
        credit_ret = 4'b1000;
        tick;
        chk("err_full", 32'(err), 32'h0);
        tick;
        credit_ret = 4'h0;
        chk("err_set", 32'(err), 32'h1);
        repeat (3) tick;
        chk("err_sticky", 32'(err), 32'h1);
        // Asynchronous reset while holding an item.
        mode = 1'b0;
        out_ready = 4'h0;
        in_valid = 1'b1;
        in_data = 8'h66;
        #1;
        chk("ar_ready", 32'(in_ready), 32'h1);
        tick;
        chk("ar_hold", 32'(out_valid), 32'h8);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        #3;
        rst_n = 1'b1;
        out_ready = 4'hF;
        in_valid = 1'b1;
        in_data = 8'h77;
        #1;
        chk("ar_first_ready", 32'(in_ready), 32'h1);
        tick;
        chk("ar_first_sel", 32'(sel), 32'h0);
        chk("ar_first_valid", 32'(out_valid), 32'h1);
        mode = 1'b1;
        fix_sel = 2'd1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'h78 + 8'(k);
            #1;
            chk("ar_credit_ready", 32'(in_ready), 32'(k < 4));
            tick;
        end
        in_valid = 1'b0;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
